// File: rtl/fifo_window_reader_pkg.sv
// Shared types and helpers for the ECG sample FIFO window reader.
package fifo_window_reader_pkg;

    localparam int unsigned DEF_LOG2_MEM_DEPTH  = 8;
    localparam int unsigned DEF_LOG2_NUM_OF_MEM = 3;
    localparam int unsigned DEF_AW              = DEF_LOG2_MEM_DEPTH + DEF_LOG2_NUM_OF_MEM;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRead,
        StDrain
    } rd_state_e;

    function automatic int unsigned addr_bank(input int unsigned addr, input int unsigned row_bits);
        return addr >> row_bits;
    endfunction

    function automatic int unsigned addr_row(input int unsigned addr, input int unsigned row_bits);
        return addr & ((32'd1 << row_bits) - 32'd1);
    endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry valid/ready output buffer fed by a 1-cycle-latency memory read, with an in-flight
// credit count so the issuer never has more than two samples outstanding.
module fifo_rd_skid_buf #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned TAG_W  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              issue_i,
    input  logic [TAG_W-1:0]  issue_tag_i,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic              pop_o,
    output logic [1:0]        outstanding_o,
    output logic              credit_ok_o
);
    localparam int unsigned EW = DATA_W + TAG_W;

    logic [EW-1:0]    mem_q [2];
    logic [EW-1:0]    mem_d [2];
    logic             wptr_q, wptr_d, rptr_q, rptr_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             inflight_q, inflight_d;
    logic [TAG_W-1:0] inflight_tag_q, inflight_tag_d;
    logic [EW-1:0]    head;
    logic             buf_pop, push;

    always_comb begin
        // An empty buffer presents the arriving read data directly.
        head          = (cnt_q != 2'd0) ? mem_q[rptr_q] : {inflight_tag_q, rd_data_i};
        valid_o       = (cnt_q != 2'd0) || inflight_q;
        pop_o         = valid_o && ready_i;
        {tag_o, data_o} = valid_o ? head : '0;
        buf_pop       = pop_o && (cnt_q != 2'd0);
        push          = inflight_q && !(pop_o && (cnt_q == 2'd0));
        outstanding_o = cnt_q + {1'b0, inflight_q};
        credit_ok_o   = outstanding_o < 2'd2;
    end

    always_comb begin
        mem_d          = mem_q;
        wptr_d         = wptr_q;
        rptr_d         = rptr_q;
        inflight_d     = issue_i;
        inflight_tag_d = issue_i ? issue_tag_i : inflight_tag_q;
        if (push) begin
            mem_d[wptr_q] = {inflight_tag_q, rd_data_i};
            wptr_d        = ~wptr_q;
        end
        if (buf_pop) begin
            rptr_d = ~rptr_q;
        end
        cnt_d = cnt_q + {1'b0, push} - {1'b0, buf_pop};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q          <= '{default: '0};
            wptr_q         <= 1'b0;
            rptr_q         <= 1'b0;
            cnt_q          <= 2'd0;
            inflight_q     <= 1'b0;
            inflight_tag_q <= '0;
        end else begin
            mem_q          <= mem_d;
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
            cnt_q          <= cnt_d;
            inflight_q     <= inflight_d;
            inflight_tag_q <= inflight_tag_d;
        end
    end

endmodule

// File: rtl/fifo_window_reader.sv
// Streams one ECG_WINDOW-sample beat window out of the circular banked FIFO per R-peak request.
// Optional FIFO_RD_OVERRUN_CHECK_EN adds overrun_o and truncates a window that catches wr_ptr.
module fifo_window_reader
    import fifo_window_reader_pkg::*;
#(
    parameter int unsigned DATA_W          = 16,
    parameter int unsigned LOG2_MEM_DEPTH  = DEF_LOG2_MEM_DEPTH,
    parameter int unsigned LOG2_NUM_OF_MEM = DEF_LOG2_NUM_OF_MEM,
    parameter int unsigned ECG_WINDOW      = 800,
    localparam int unsigned AW             = LOG2_MEM_DEPTH + LOG2_NUM_OF_MEM
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       loop_offset_en,
    input  logic [AW-1:0]              loop_offset,
    input  logic [AW-1:0]              wr_ptr,
    output logic                       rd_en_o,
    output logic [LOG2_NUM_OF_MEM-1:0] rd_bank_o,
    output logic [LOG2_MEM_DEPTH-1:0]  rd_row_o,
    input  logic [DATA_W-1:0]          rd_data,
    output logic [DATA_W-1:0]          sample_o,
    output logic                       sample_valid_o,
    input  logic                       sample_ready,
    output logic                       window_start_o,
    output logic                       window_last_o,
    output logic                       busy_o,
    output logic                       req_drop_o
`ifdef FIFO_RD_OVERRUN_CHECK_EN
    ,
    output logic                       overrun_o
`endif
);
    localparam logic [AW-1:0] WIN_AW   = AW'(ECG_WINDOW);
    localparam logic [AW-1:0] LAST_IDX = AW'(ECG_WINDOW - 1);

    rd_state_e     state_q, state_d;
    logic [AW-1:0] addr_q, addr_d, cnt_q, cnt_d, pend_addr_q, pend_addr_d, start_addr;
    logic          pend_q, pend_d, ovr_q, ovr_d, drop_q, drop_d;
    logic          take_req, take_pend, last_acc, ovr_now;
    logic [1:0]    issue_tag, out_tag, outstanding;
    logic          pop, credit_ok;

`ifdef FIFO_RD_OVERRUN_CHECK_EN
    assign ovr_now   = (state_q == StRead) && (wr_ptr == addr_q);
    assign overrun_o = ovr_now;
`else
    assign ovr_now = 1'b0;
`endif

    assign issue_tag = {cnt_q == '0, cnt_q == LAST_IDX};

    fifo_rd_skid_buf #(
        .DATA_W (DATA_W),
        .TAG_W  (2)
    ) u_skid (
        .clk           (clk),
        .reset_n       (reset_n),
        .issue_i       (rd_en_o),
        .issue_tag_i   (issue_tag),
        .rd_data_i     (rd_data),
        .ready_i       (sample_ready),
        .valid_o       (sample_valid_o),
        .data_o        (sample_o),
        .tag_o         (out_tag),
        .pop_o         (pop),
        .outstanding_o (outstanding),
        .credit_ok_o   (credit_ok)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            ovr_q       <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            ovr_q       <= ovr_d;
            drop_q      <= drop_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        ovr_d       = ovr_q;
        drop_d      = 1'b0;
        take_req    = 1'b0;
        take_pend   = 1'b0;
        start_addr  = wr_ptr - WIN_AW + loop_offset;
        last_acc    = (outstanding == 2'd0) || (pop && (outstanding == 2'd1));
        unique case (state_q)
            StIdle: begin
                if (pend_q) begin
                    state_d   = StLoad;
                    addr_d    = pend_addr_q;
                    take_pend = 1'b1;
                end else if (loop_offset_en) begin
                    state_d  = StLoad;
                    addr_d   = start_addr;
                    take_req = 1'b1;
                end
            end
            StLoad: begin
                cnt_d   = '0;
                state_d = StRead;
            end
            StRead: begin
                if (ovr_now) begin
                    ovr_d   = 1'b1;
                    state_d = StDrain;
                end else if (rd_en_o) begin
                    addr_d = addr_q + AW'(1);
                    cnt_d  = cnt_q + AW'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (last_acc) begin
                    ovr_d = 1'b0;
                    if (pend_q) begin
                        state_d   = StLoad;
                        addr_d    = pend_addr_q;
                        take_pend = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A slot freed this cycle can absorb a simultaneous request.
        if (take_pend) begin
            pend_d = 1'b0;
        end
        if (loop_offset_en && !take_req) begin
            if (pend_q && !take_pend) begin
                drop_d = 1'b1;
            end else begin
                pend_d      = 1'b1;
                pend_addr_d = start_addr;
            end
        end
    end

    always_comb begin
        rd_en_o        = (state_q == StRead) && credit_ok && !ovr_now;
        busy_o         = state_q != StIdle;
        req_drop_o     = drop_q;
        window_start_o = sample_valid_o && out_tag[1];
        // After an overrun the youngest outstanding sample closes the window.
        window_last_o  = sample_valid_o &&
                         (out_tag[0] || ((ovr_q || ovr_now) && (outstanding == 2'd1)));
        rd_bank_o      = LOG2_NUM_OF_MEM'(addr_bank(32'(addr_q), LOG2_MEM_DEPTH));
        rd_row_o       = LOG2_MEM_DEPTH'(addr_row(32'(addr_q), LOG2_MEM_DEPTH));
    end

endmodule

// File: tb/tb_fifo_window_reader.sv
// Scoreboard bench for fifo_window_reader: expected addresses and samples are queued at request
// time and popped by a negedge monitor whenever the DUT reads or hands over a sample.
`timescale 1ns/1ps
module tb_fifo_window_reader;
    localparam int unsigned DW  = 16;
    localparam int unsigned LMD = 8;
    localparam int unsigned LNM = 3;
    localparam int unsigned AW  = 11;
    localparam int unsigned WIN = 800;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           loop_offset_en = 1'b0;
    logic           sample_ready = 1'b0;
    logic [AW-1:0]  loop_offset = '0;
    logic [AW-1:0]  wr_ptr = '0;
    logic [DW-1:0]  rd_data = '0;
    logic           rd_en_o, sample_valid_o, window_start_o, window_last_o, busy_o, req_drop_o;
    logic [LNM-1:0] rd_bank_o;
    logic [LMD-1:0] rd_row_o;
    logic [DW-1:0]  sample_o;
`ifdef FIFO_RD_OVERRUN_CHECK_EN
    logic           overrun_o;
`endif

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int req_cyc = 0;
    int acc_total = 0;
    int start_cyc = 0;
    int end_cyc = 0;
    int ovr_pulses = 0;
    int rmode = 0;
    logic          stall = 1'b0;
    logic [DW+1:0] held = '0;
    logic [DW+1:0] exp_q [$];
    logic [AW-1:0] addr_q [$];

    fifo_window_reader u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .loop_offset_en (loop_offset_en),
        .loop_offset    (loop_offset),
        .wr_ptr         (wr_ptr),
        .rd_en_o        (rd_en_o),
        .rd_bank_o      (rd_bank_o),
        .rd_row_o       (rd_row_o),
        .rd_data        (rd_data),
        .sample_o       (sample_o),
        .sample_valid_o (sample_valid_o),
        .sample_ready   (sample_ready),
        .window_start_o (window_start_o),
        .window_last_o  (window_last_o),
        .busy_o         (busy_o),
        .req_drop_o     (req_drop_o)
`ifdef FIFO_RD_OVERRUN_CHECK_EN
        ,
        .overrun_o      (overrun_o)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {a[4:0] ^ 5'h0B, a};
    endfunction

    // Synchronous memory: data appears the cycle after the strobe.
    always @(posedge clk) rd_data <= rd_en_o ? mem_word({rd_bank_o, rd_row_o}) : 16'hDEAD;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name, input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s (t=%0t)", name, what, $time);
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (rd_en_o) begin
                if (addr_q.size() == 0) flag("rd_addr", "read with no expected address");
                else check("rd_addr", 32'({rd_bank_o, rd_row_o}), 32'(addr_q.pop_front()));
            end
            if (stall) begin
                check("hold", 32'({sample_valid_o, window_start_o, window_last_o, sample_o}),
                      32'({1'b1, held}));
            end
            stall = sample_valid_o && !sample_ready;
            held  = {window_start_o, window_last_o, sample_o};
            if (sample_valid_o && sample_ready) begin
                acc_total++;
                if (window_start_o) start_cyc = cyc;
                if (window_last_o) end_cyc = cyc;
                if (exp_q.size() == 0) flag("sample", "sample with no expectation");
                else check("sample", 32'({window_start_o, window_last_o, sample_o}),
                           32'(exp_q.pop_front()));
            end
`ifdef FIFO_RD_OVERRUN_CHECK_EN
            if (overrun_o) ovr_pulses++;
`endif
        end else begin
            stall = 1'b0;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                1:       sample_ready = ~sample_ready;
                2:       sample_ready = 1'($urandom_range(0, 1));
                default: sample_ready = 1'b1;
            endcase
        end
    end

    task automatic push_window(input logic [AW-1:0] wr, input logic [AW-1:0] off, input int n);
        logic [AW-1:0] a;
        a = wr - AW'(WIN) + off;
        for (int i = 0; i < n; i++) begin
            addr_q.push_back(a);
            exp_q.push_back({i == 0, i == n - 1, mem_word(a)});
            a = a + AW'(1);
        end
    endtask

    task automatic request(input logic [AW-1:0] wr, input logic [AW-1:0] off);
        @(posedge clk);
        #1;
        wr_ptr         = wr;
        loop_offset    = off;
        loop_offset_en = 1'b1;
        req_cyc        = cyc;
        @(posedge clk);
        #1;
        loop_offset_en = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || busy_o) && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({name, " busy"}, 32'(busy_o), 32'd0);
        check({name, " left"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_acc(input string name, input int n);
        int base = acc_total;
        int k = 0;
        while (acc_total - base < n && k < 5000) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({name, " reached"}, 32'(acc_total - base >= n), 32'd1);
    endtask

    task automatic check_quiet(input string name);
        check({name, " valid"}, 32'(sample_valid_o), 32'd0);
        check({name, " rd_en"}, 32'(rd_en_o), 32'd0);
        check({name, " busy"}, 32'(busy_o), 32'd0);
        check({name, " flags"}, 32'({window_start_o, window_last_o, req_drop_o}), 32'd0);
        check({name, " data"}, 32'(sample_o), 32'd0);
        check({name, " addr"}, 32'({rd_bank_o, rd_row_o}), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Plain window, full throughput.
        push_window(11'd1000, 11'd0, WIN);
        request(11'd1000, 11'd0);
        wait_done("t1", 1200);
        check("t1 latency", 32'(start_cyc - req_cyc), 32'd3);
        check("t1 duration", 32'(end_cyc - req_cyc), 32'd802);

        // Window wrapping past address 2047.
        push_window(11'd300, 11'd0, WIN);
        request(11'd300, 11'd0);
        wait_done("t2", 1200);

        // Backpressure: toggling then random ready, offset acting as -8.
        rmode = 1;
        push_window(11'd1200, 11'd0, WIN);
        request(11'd1200, 11'd0);
        wait_done("t3a", 2500);
        rmode = 2;
        push_window(11'd1700, 11'd2040, WIN);
        request(11'd1700, 11'd2040);
        wait_done("t3b", 5000);
        rmode = 0;

        // Pending slot and drop.
        push_window(11'd1000, 11'd0, WIN);
        request(11'd1000, 11'd0);
        wait_acc("t4 a", 100);
        push_window(11'd1010, 11'd0, WIN);
        request(11'd1010, 11'd0);
        check("t4 kept", 32'(req_drop_o), 32'd0);
        wait_acc("t4 b", 100);
        request(11'd1010, 11'd0);
        check("t4 drop", 32'(req_drop_o), 32'd1);
        @(posedge clk);
        #1;
        check("t4 drop pulse", 32'(req_drop_o), 32'd0);
        wait_done("t4", 2500);

        // Reset mid-window, then a clean window.
        push_window(11'd1000, 11'd0, WIN);
        request(11'd1000, 11'd0);
        wait_acc("t5", 400);
        reset_n = 1'b0;
        @(negedge clk);
        check_quiet("t5 abort");
        exp_q.delete();
        addr_q.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        push_window(11'd1000, 11'd0, WIN);
        request(11'd1000, 11'd0);
        wait_done("t5 rerun", 1200);

`ifdef FIFO_RD_OVERRUN_CHECK_EN
        // Writer catches the reader at address 260: stream ends on sample 60.
        push_window(11'd1000, 11'd0, 60);
        request(11'd1000, 11'd0);
        wait_acc("t6", 50);
        wr_ptr = 11'd260;
        wait_done("t6", 200);
        check("t6 overrun pulses", 32'(ovr_pulses), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
